// File: rtl/btn_cond.sv
// Push-button conditioner: 2-flop sync, debounce, press and long-press pulses per button.
// Define BTN_REPEAT_EN to add auto-repeat press pulses while a long press is held.
module btn_cond #(
  parameter int DEB_CYCLES    = 2000000,
  parameter int LONG_CYCLES   = 100000000,
  parameter int REPEAT_CYCLES = 20000000,
  parameter int CNT_W         = 27
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt,
  input  logic       l_bt,
  input  logic       r_bt,
  input  logic       u_bt,
  input  logic       d_bt,
  output logic [4:0] level,
  output logic [4:0] press,
  output logic [4:0] long_press,
  output logic       any_press
);

  typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_t;

  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEB_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
  localparam logic [CNT_W-1:0] LONG_MAX  = CNT_W'(LONG_CYCLES);

  logic [4:0]       raw;
  logic [4:0]       s1;
  logic [4:0]       s2;
  logic [CNT_W-1:0] deb_cnt  [5];
  logic [CNT_W-1:0] hold_cnt [5];
  state_t           state    [5];
  logic [4:0]       accept;
  logic [4:0]       rise;
  logic [4:0]       fall;
  logic [4:0]       long_hit;
  logic [4:0]       press_nxt;

  assign raw = {d_bt, u_bt, r_bt, l_bt, bt};

  always_comb begin
    accept   = '0;
    rise     = '0;
    fall     = '0;
    long_hit = '0;
    for (int i = 0; i < 5; i++) begin
      accept[i]   = (s2[i] != level[i]) && (deb_cnt[i] == DEB_LAST);
      rise[i]     = accept[i] && s2[i];
      fall[i]     = accept[i] && !s2[i];
      long_hit[i] = (state[i] == S_HELD) && level[i] && (hold_cnt[i] == LONG_LAST);
    end
  end

`ifdef BTN_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);

  logic [CNT_W-1:0] rep_cnt [5];
  logic [4:0]       rep_hit;

  always_comb begin
    rep_hit = '0;
    for (int i = 0; i < 5; i++) begin
      rep_hit[i] = (state[i] == S_LONG) && level[i] && (rep_cnt[i] == REP_LAST);
    end
  end

  assign press_nxt = rise | rep_hit;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 5; i++) begin
      if (rst || state[i] != S_LONG || !level[i] || fall[i] || rep_hit[i]) begin
        rep_cnt[i] <= '0;
      end else begin
        rep_cnt[i] <= rep_cnt[i] + CNT_W'(1);
      end
    end
  end
`else
  assign press_nxt = rise;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1         <= '0;
      s2         <= '0;
      level      <= '0;
      press      <= '0;
      long_press <= '0;
      any_press  <= 1'b0;
      for (int i = 0; i < 5; i++) begin
        deb_cnt[i]  <= '0;
        hold_cnt[i] <= '0;
        state[i]    <= S_IDLE;
      end
    end else begin
      s1         <= raw;
      s2         <= s1;
      press      <= press_nxt;
      long_press <= long_hit;
      any_press  <= |press_nxt;
      for (int i = 0; i < 5; i++) begin
        if (s2[i] == level[i]) begin
          deb_cnt[i] <= '0;
        end else if (accept[i]) begin
          level[i]   <= s2[i];
          deb_cnt[i] <= '0;
        end else begin
          deb_cnt[i] <= deb_cnt[i] + CNT_W'(1);
        end

        // hold_cnt parks at LONG_MAX so long_hit fires once per hold
        if (!level[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != LONG_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + CNT_W'(1);
        end

        case (state[i])
          S_IDLE: if (rise[i]) state[i] <= S_HELD;
          S_HELD: begin
            if (fall[i])          state[i] <= S_IDLE;
            else if (long_hit[i]) state[i] <= S_LONG;
          end
          S_LONG: if (fall[i]) state[i] <= S_IDLE;
          default: state[i] <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_btn_cond.sv
// Bench for btn_cond: window-based reference model checked every cycle, directed
// scenarios with literal latencies, then randomized button activity with random resets.
module tb_btn_cond;
  localparam int DEB  = 4;
  localparam int LONG = 20;
  localparam int REP  = 8;
  localparam int MAXC = 8192;

  logic       clk;
  logic       rst;
  logic [4:0] btn;
  logic [4:0] level;
  logic [4:0] press;
  logic [4:0] long_press;
  logic       any_press;

  btn_cond #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG), .REPEAT_CYCLES(REP), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .bt(btn[0]), .l_bt(btn[1]), .r_bt(btn[2]), .u_bt(btn[3]), .d_bt(btn[4]),
    .level(level), .press(press), .long_press(long_press), .any_press(any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model state, written only by the posedge model process
  int         cyc = 0;
  int         last_rst = 0;
  bit         valid = 1'b0;
  bit [4:0]   raw_h [0:MAXC-1];
  bit         rst_h [0:MAXC-1];
  int         p_edge [5];
  logic [4:0] m_level = '0;
  logic [4:0] m_press = '0;
  logic [4:0] m_long  = '0;
  logic       m_any   = 1'b0;

  // DUT output history, written only by the main process
  logic [4:0] dp_h [0:MAXC-1];
  logic [4:0] dl_h [0:MAXC-1];
  logic [4:0] dv_h [0:MAXC-1];
  logic       da_h [0:MAXC-1];

  int checks = 0;
  int failures = 0;

  // synchronised value seen by the debouncer just before edge t
  function automatic bit syn(int t, int i);
    if (rst_h[t-1] || rst_h[t-2]) return 1'b0;
    return raw_h[t-2][i];
  endfunction

  always @(posedge clk) begin
    int t;
    int d;
    bit flip;
    logic [4:0] old;
    logic [4:0] np;
    logic [4:0] nl;
    cyc = cyc + 1;
    t = cyc;
    if (t < MAXC) begin
      raw_h[t] = btn;
      rst_h[t] = rst;
      if (rst) begin
        valid = 1'b1;
        last_rst = t;
        m_level = '0;
        m_press = '0;
        m_long = '0;
        m_any = 1'b0;
        for (int i = 0; i < 5; i++) p_edge[i] = -100000;
      end else if (valid) begin
        old = m_level;
        np = '0;
        nl = '0;
        for (int i = 0; i < 5; i++) begin
          if (old[i]) begin
            d = t - p_edge[i];
            if (d == LONG) nl[i] = 1'b1;
`ifdef BTN_REPEAT_EN
            if (d > LONG && ((d - LONG) % REP) == 0) np[i] = 1'b1;
`endif
          end
          if (t - DEB + 1 > last_rst) begin
            flip = 1'b1;
            for (int k = 0; k < DEB; k++) if (syn(t - k, i) == old[i]) flip = 1'b0;
            if (flip) begin
              m_level[i] = ~old[i];
              if (!old[i]) begin
                np[i] = 1'b1;
                p_edge[i] = t;
              end
            end
          end
        end
        m_press = np;
        m_long = nl;
        m_any = |np;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d actual=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    if (cyc < MAXC) begin
      dp_h[cyc] = press;
      dl_h[cyc] = long_press;
      dv_h[cyc] = level;
      da_h[cyc] = any_press;
    end
    if (valid) begin
      chk("level", 32'(level), 32'(m_level));
      chk("press", 32'(press), 32'(m_press));
      chk("long_press", 32'(long_press), 32'(m_long));
      chk("any_press", 32'(any_press), 32'(m_any));
    end
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  // kind: 0 press, 1 long_press, 2 level, 3 any_press
  function automatic bit ev(int kind, int t, int i);
    case (kind)
      0: return dp_h[t][i];
      1: return dl_h[t][i];
      2: return dv_h[t][i];
      default: return da_h[t];
    endcase
  endfunction

  function automatic int cnt_ev(int kind, int i, int a, int b);
    int n = 0;
    for (int t = a; t <= b; t++) if (ev(kind, t, i)) n++;
    return n;
  endfunction

  function automatic int first_ev(int kind, int i, int a, int b);
    for (int t = a; t <= b; t++) if (ev(kind, t, i)) return t;
    return -1;
  endfunction

  function automatic int last_ev(int kind, int i, int a, int b);
    for (int t = b; t >= a; t--) if (ev(kind, t, i)) return t;
    return -1;
  endfunction

  initial begin
    int e;
    int e0;
    int p;
    int r;
    int rem [5];
    rst = 1'b1;
    btn = '0;

    // reset, then release with bt already high
    ticks(3);
    chk("reset_outputs", 32'({level, press, long_press, any_press}), 32'd0);
    rst = 1'b0;
    btn = 5'b00001;
    e = cyc + 1;
    ticks(12);
    chk("rst_bt_latency", 32'(first_ev(0, 0, e, cyc) - e), 32'd5);
    chk("rst_bt_count", 32'(cnt_ev(0, 0, e, cyc)), 32'd1);
    btn = '0;
    ticks(12);

    // bounce on u_bt
    e0 = cyc + 1;
    for (int k = 0; k < 20; k++) begin
      btn[3] = ((k % 4) < 2);
      tick();
    end
    chk("bounce_quiet", 32'(cnt_ev(0, 3, e0, cyc)), 32'd0);
    btn[3] = 1'b1;
    e = cyc + 1;
    ticks(12);
    chk("bounce_count", 32'(cnt_ev(0, 3, e0, cyc)), 32'd1);
    chk("bounce_latency", 32'(first_ev(0, 3, e0, cyc) - e), 32'd5);
    btn[3] = 1'b0;
    ticks(12);

    // 3-cycle glitch on r_bt
    e0 = cyc + 1;
    btn[2] = 1'b1;
    ticks(3);
    btn[2] = 1'b0;
    ticks(12);
    chk("glitch_press", 32'(cnt_ev(0, 2, e0, cyc)), 32'd0);
    chk("glitch_level", 32'(cnt_ev(2, 2, e0, cyc)), 32'd0);

    // long press on l_bt
    btn[1] = 1'b1;
    e = cyc + 1;
    ticks(40);
    btn[1] = 1'b0;
    ticks(12);
    p = first_ev(0, 1, e, cyc);
    chk("long_press_latency", 32'(p - e), 32'd5);
    chk("long_pulse_offset", 32'(first_ev(1, 1, e, cyc) - p), 32'd20);
    chk("long_pulse_count", 32'(cnt_ev(1, 1, e, cyc)), 32'd1);
`ifdef BTN_REPEAT_EN
    chk("long_press_count", 32'(cnt_ev(0, 1, e, cyc)), 32'd3);
    chk("repeat_last_offset", 32'(last_ev(0, 1, e, cyc) - p), 32'd36);
`else
    chk("long_press_count", 32'(cnt_ev(0, 1, e, cyc)), 32'd1);
`endif

    // simultaneous bt and d_bt
    btn = 5'b10001;
    e = cyc + 1;
    ticks(12);
    chk("simul_bt_at", 32'(first_ev(0, 0, e, cyc) - e), 32'd5);
    chk("simul_d_at", 32'(first_ev(0, 4, e, cyc) - e), 32'd5);
    chk("simul_any_at", 32'(first_ev(3, 0, e, cyc) - e), 32'd5);
    chk("simul_any_count", 32'(cnt_ev(3, 0, e, cyc)), 32'd1);
    btn = '0;
    ticks(12);

    // reset in the middle of a d_bt hold
    btn[4] = 1'b1;
    e = cyc + 1;
    ticks(15);
    rst = 1'b1;
    tick();
    r = cyc;
    rst = 1'b0;
    ticks(40);
    chk("midrst_first_press", 32'(first_ev(0, 4, e, r) - e), 32'd5);
    chk("midrst_long_count", 32'(cnt_ev(1, 4, e, cyc)), 32'd1);
    chk("midrst_new_press", 32'(first_ev(0, 4, r + 1, cyc) - (r + 1)), 32'd5);
    chk("midrst_new_long", 32'(first_ev(1, 4, r + 1, cyc) - (r + 1)), 32'd25);
    chk("midrst_press_count", 32'(cnt_ev(0, 4, r + 1, r + 25)), 32'd1);
    btn = '0;
    ticks(12);

    // randomized activity: short glitches, medium and long holds, rare resets
    for (int i = 0; i < 5; i++) rem[i] = $urandom_range(1, 8);
    repeat (3000) begin
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 5; i++) begin
        if (rem[i] == 0) begin
          btn[i] = ~btn[i];
          rem[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(20, 60) : $urandom_range(1, 8);
        end else begin
          rem[i] = rem[i] - 1;
        end
      end
      tick();
    end
    rst = 1'b0;
    btn = '0;
    ticks(20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
